sync_fifo_ext: RTL and testbench
================================

SYNC_FIFO_EXT -- requirements
Module: sync_fifo_ext

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 32, words stored (>=2, any integer, power of two not required).
REQ-003 SHALL have parameter FWFT, default 1: 1 = first-word-fall-through read, 0 = registered read.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1, rising-edge clock; rst_i input 1, async active-high reset.
REQ-005 SHALL provide these ports (CW = $clog2(FIFO_DEPTH+1)):
- flush_i  input  1  sync clear of contents and flags
- write_i  input  1  write request
- wr_data_i  input  DATA_WIDTH  write word
- read_i  input  1  read request
- rd_data_o  output  DATA_WIDTH  read word
- rd_valid_o  output  1  rd_data_o holds a valid word
- full_o  output  1  count == FIFO_DEPTH
- empty_o  output  1  count == 0
- almost_full_o  output  1  count >= af_thresh_i
- almost_empty_o  output  1  count <= ae_thresh_i
- af_thresh_i  input  CW  almost-full threshold
- ae_thresh_i  input  CW  almost-empty threshold
- count_o  output  CW  words currently stored
- overflow_o  output  1  sticky: write attempted while full
- underflow_o  output  1  sticky: read attempted while empty

Function
REQ-006 Write SHALL be accepted iff write_i=1 and full_o=0; accepted write stores wr_data_i at write pointer on the rising edge.
REQ-007 Read SHALL be accepted iff read_i=1 and empty_o=0; accepted read advances read pointer.
REQ-008 Pointers SHALL increment by one per accepted op and wrap from FIFO_DEPTH-1 to 0.
REQ-009 count_o SHALL update next edge: +1 write-only, -1 read-only, unchanged for both accepted or neither.
REQ-010 full_o, empty_o, almost_full_o, almost_empty_o SHALL be registered, computed from next count, valid in the same cycle as the new count_o.
REQ-011 Simultaneous write+read when full: read accepted, write rejected, count becomes FIFO_DEPTH-1, overflow_o set.
REQ-012 Simultaneous write+read when empty: write accepted, read rejected, count becomes 1, underflow_o set.
REQ-013 overflow_o/underflow_o SHALL set on the edge after the offending request and stay 1 until reset or flush.
REQ-014 FWFT=1: rd_data_o SHALL combinationally show memory at read pointer; rd_valid_o = !empty_o.
REQ-015 FWFT=0: on accepted read, rd_data_o SHALL load head word on that edge and rd_valid_o SHALL pulse 1 for exactly the following cycle; rd_data_o holds its value otherwise.
REQ-016 flush_i=1 SHALL on the next edge zero pointers and count, set empty_o=1, full_o=0, recompute almost flags for count 0, clear sticky flags, rd_valid_o=0; flush overrides write_i/read_i in that cycle.
REQ-017 Threshold inputs SHALL be sampled every cycle; changing them updates almost flags on the next edge even without an access.
REQ-018 Memory contents SHALL NOT be reset or cleared; only control state is.

Reset
REQ-019 While rst_i=1 (asynchronously, any time incl. mid-operation): pointers=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, rd_valid_o=0, rd_data_o=0 (FWFT=0), almost_full_o=(af_thresh_i==0), almost_empty_o=1.
REQ-020 First access SHALL be accepted on the first rising edge after rst_i deasserts.

Verification
REQ-021 DEPTH=5, FWFT=1: write 1..5 -> full_o=1, count_o=5; 6th write -> rejected, overflow_o=1; read 5 -> data 1..5 in order, empty_o=1.
REQ-022 DEPTH=5: 3 writes, 3 reads, repeated 4 times -> pointers wrap past 4 to 0, data order preserved, count_o returns to 0.
REQ-023 FWFT=0: write 0xA5, read -> rd_data_o=0xA5 with rd_valid_o=1 one cycle after the read edge, 0 next cycle.
REQ-024 af_thresh_i=4, ae_thresh_i=1: counts 0..5 -> almost_empty_o=1 at 0,1; almost_full_o=1 at 4,5.
REQ-025 Full FIFO, write+read same cycle -> count 4, overflow_o=1; empty FIFO, write+read -> count 1, underflow_o=1; flush_i with write_i=1 -> count 0, both sticky flags 0.
REQ-026 Assert rst_i mid-burst between edges -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_ext.sv
// Synchronous FIFO with registered status flags, sticky error flags
// and a selectable first-word-fall-through or registered read port.
module sync_fifo_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 32,
  parameter int FWFT       = 1,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  input  logic [CW-1:0]         af_thresh_i,
  input  logic [CW-1:0]         ae_thresh_i,
  output logic [CW-1:0]         count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic          full_q;
  logic          empty_q;
  logic          af_q;
  logic          ae_q;
  logic          ov_q;
  logic          un_q;
  logic          wr_acc;
  logic          rd_acc;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wr_acc = write_i & ~full_q & ~flush_i;
  assign rd_acc = read_i & ~empty_q & ~flush_i;

  always_comb begin
    cnt_n = cnt_q;
    unique case (1'b1)
      flush_i:           cnt_n = '0;
      wr_acc & ~rd_acc:  cnt_n = cnt_q + CW'(1);
      rd_acc & ~wr_acc:  cnt_n = cnt_q - CW'(1);
      default:           cnt_n = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ov_q     <= 1'b0;
      un_q     <= 1'b0;
    end else begin
      cnt_q   <= cnt_n;
      full_q  <= (cnt_n == CW'(FIFO_DEPTH));
      empty_q <= (cnt_n == '0);
      af_q    <= (cnt_n >= af_thresh_i);
      ae_q    <= (cnt_n <= ae_thresh_i);
      if (flush_i) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        ov_q     <= 1'b0;
        un_q     <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr_q <= inc(wr_ptr_q);
        if (rd_acc) rd_ptr_q <= inc(rd_ptr_q);
        ov_q <= ov_q | (write_i & full_q);
        un_q <= un_q | (read_i & empty_q);
      end
    end
  end

  // storage is deliberately left out of reset
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data_o  = mem[rd_ptr_q];
      assign rd_valid_o = ~empty_q;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rd_ptr_q];
        end
      end
      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

  assign count_o        = cnt_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  // flag follows the live threshold while held in reset
  assign almost_full_o  = rst_i ? (af_thresh_i == '0) : af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ov_q;
  assign underflow_o    = un_q;

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench: depth-5 FWFT instance plus a depth-5 registered-read
// instance sharing clock, reset, flush and thresholds.
module tb_sync_fifo_ext;

  localparam int DW = 8;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_a = 1'b0;
  logic          rd_a = 1'b0;
  logic [DW-1:0] wd_a = '0;
  logic          wr_b = 1'b0;
  logic          rd_b = 1'b0;
  logic [DW-1:0] wd_b = '0;
  logic [CW-1:0] af_th = CW'(4);
  logic [CW-1:0] ae_th = CW'(1);

  logic [DW-1:0] rdat_a, rdat_b;
  logic          rv_a, rv_b;
  logic          full_a, full_b, emp_a, emp_b;
  logic          af_a, af_b, ae_a, ae_b;
  logic [CW-1:0] cnt_a, cnt_b;
  logic          ov_a, ov_b, un_a, un_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(1)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .write_i(wr_a), .wr_data_i(wd_a), .read_i(rd_a),
    .rd_data_o(rdat_a), .rd_valid_o(rv_a),
    .full_o(full_a), .empty_o(emp_a),
    .almost_full_o(af_a), .almost_empty_o(ae_a),
    .af_thresh_i(af_th), .ae_thresh_i(ae_th),
    .count_o(cnt_a), .overflow_o(ov_a), .underflow_o(un_a)
  );

  sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(0)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .write_i(wr_b), .wr_data_i(wd_b), .read_i(rd_b),
    .rd_data_o(rdat_b), .rd_valid_o(rv_b),
    .full_o(full_b), .empty_o(emp_b),
    .almost_full_o(af_b), .almost_empty_o(ae_b),
    .af_thresh_i(af_th), .ae_thresh_i(ae_th),
    .count_o(cnt_b), .overflow_o(ov_b), .underflow_o(un_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic st_a(input string tag, input int c, input bit f,
                      input bit e, input bit af, input bit ae,
                      input bit ov, input bit un);
    check({tag, ".cnt"}, 32'(cnt_a), 32'(c));
    check({tag, ".full"}, 32'(full_a), 32'(f));
    check({tag, ".empty"}, 32'(emp_a), 32'(e));
    check({tag, ".af"}, 32'(af_a), 32'(af));
    check({tag, ".ae"}, 32'(ae_a), 32'(ae));
    check({tag, ".ov"}, 32'(ov_a), 32'(ov));
    check({tag, ".un"}, 32'(un_a), 32'(un));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_a(input bit w, input logic [DW-1:0] d, input bit r);
    wr_a = w;
    wd_a = d;
    rd_a = r;
    tick();
    wr_a = 1'b0;
    rd_a = 1'b0;
  endtask

  task automatic do_flush(input bit w);
    flush = 1'b1;
    wr_a  = w;
    tick();
    flush = 1'b0;
    wr_a  = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    st_a("rst", 0, 0, 1, 0, 1, 0, 0);
    check("rst.rv_a", 32'(rv_a), 0);
    check("rst.rv_b", 32'(rv_b), 0);
    check("rst.rd_b", 32'(rdat_b), 0);
    tick();
    rst = 1'b0;

    // fill 1..5, flags tracked against af=4 / ae=1
    for (int i = 1; i <= D; i++) begin
      op_a(1'b1, DW'(i), 1'b0);
      st_a($sformatf("fill%0d", i), i, i == D, 0, i >= 4, i <= 1, 0, 0);
      check($sformatf("fill%0d.head", i), 32'(rdat_a), 1);
      check($sformatf("fill%0d.rv", i), 32'(rv_a), 1);
    end

    op_a(1'b1, 8'h66, 1'b0);
    st_a("ovf", 5, 1, 0, 1, 0, 1, 0);

    for (int i = 1; i <= D; i++) begin
      check($sformatf("drain%0d.data", i), 32'(rdat_a), 32'(i));
      op_a(1'b0, '0, 1'b1);
      check($sformatf("drain%0d.cnt", i), 32'(cnt_a), 32'(D - i));
    end
    st_a("drained", 0, 0, 1, 0, 1, 1, 0);
    check("drained.rv", 32'(rv_a), 0);

    op_a(1'b1, 8'h77, 1'b1);
    st_a("wr_rd_empty", 1, 0, 0, 0, 1, 1, 1);
    check("wr_rd_empty.head", 32'(rdat_a), 32'h77);

    do_flush(1'b1);
    st_a("flush", 0, 0, 1, 0, 1, 0, 0);
    check("flush.rv", 32'(rv_a), 0);

    for (int i = 0; i < D; i++) op_a(1'b1, DW'(8'h10 + i), 1'b0);
    st_a("refill", 5, 1, 0, 1, 0, 0, 0);
    op_a(1'b1, 8'h99, 1'b1);
    st_a("wr_rd_full", 4, 0, 0, 1, 0, 1, 0);
    check("wr_rd_full.head", 32'(rdat_a), 32'h11);

    do_flush(1'b0);
    st_a("flush2", 0, 0, 1, 0, 1, 0, 0);

    // 3-in/3-out bursts walk both pointers past the wrap point
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++) op_a(1'b1, DW'(16 * k + j), 1'b0);
      check($sformatf("wrap%0d.cnt3", k), 32'(cnt_a), 3);
      for (int j = 0; j < 3; j++) begin
        check($sformatf("wrap%0d.d%0d", k, j), 32'(rdat_a),
              32'(16 * k + j));
        op_a(1'b0, '0, 1'b1);
      end
      check($sformatf("wrap%0d.cnt0", k), 32'(cnt_a), 0);
    end
    check("wrap.empty", 32'(emp_a), 1);

    af_th = '0;
    tick();
    check("thr.af0", 32'(af_a), 1);
    af_th = CW'(4);
    op_a(1'b1, 8'h01, 1'b0);
    check("thr.af4", 32'(af_a), 0);
    check("thr.ae1", 32'(ae_a), 1);
    ae_th = '0;
    tick();
    check("thr.ae0", 32'(ae_a), 0);
    ae_th = CW'(1);
    do_flush(1'b0);

    // registered read port
    wr_b = 1'b1;
    wd_b = 8'hA5;
    tick();
    wr_b = 1'b0;
    check("reg.rv_idle", 32'(rv_b), 0);
    rd_b = 1'b1;
    tick();
    rd_b = 1'b0;
    check("reg.data", 32'(rdat_b), 32'hA5);
    check("reg.rv1", 32'(rv_b), 1);
    tick();
    check("reg.rv0", 32'(rv_b), 0);
    check("reg.hold", 32'(rdat_b), 32'hA5);

    // async reset in the middle of a write burst
    for (int i = 0; i < 3; i++) op_a(1'b1, DW'(i), 1'b0);
    check("burst.cnt", 32'(cnt_a), 3);
    wr_a = 1'b1;
    wd_a = 8'h55;
    #2 rst = 1'b1;
    #1;
    st_a("arst", 0, 0, 1, 0, 1, 0, 0);
    check("arst.rv_a", 32'(rv_a), 0);
    check("arst.rd_b", 32'(rdat_b), 0);
    af_th = '0;
    #1;
    check("arst.af_thr0", 32'(af_a), 1);
    wr_a = 1'b0;
    af_th = CW'(4);
    #1 rst = 1'b0;
    op_a(1'b1, 8'h3C, 1'b0);
    check("post_rst.cnt", 32'(cnt_a), 1);
    check("post_rst.head", 32'(rdat_a), 32'h3C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1);
  end

endmodule
